// File: rtl/uart_stream_fifo_if.sv
// AXI4-Lite channel bundle between uart_stream_fifo (master) and a UART Lite
// slave.
//   ar: araddr/arvalid/arready        r: rdata/rresp/rvalid/rready
//   aw: awaddr/awvalid/awready        w: wdata/wstrb/wvalid/wready
//   b : bresp/bvalid/bready
// Widths: address 32, data 32, strobe 4, response 2.
interface uart_stream_fifo_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/uart_stream_fifo.sv
// Byte FIFO pair between the core load/store port and an AXI4-Lite UART Lite.
// The AXI engine polls the UART RX register into the RX FIFO and drains the
// TX FIFO into the UART TX register, one transaction at a time, TX first.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   renable/rsize       read request (00 byte, 01 half, 11 word, 10 reserved)
//   rdata/rdone         read data (first byte in MSB lane used) / done pulse
//   wenable/wsize/wdata write request; half/word pushed MSB byte first
//   wdone               write done pulse
//   rx_level/tx_level   bytes held in each FIFO
//   uart                AXI4-Lite master port
module uart_stream_fifo #(
    parameter int          RX_AW   = 11,
    parameter int          TX_AW   = 9,
    parameter logic [31:0] RX_ADDR = 32'h0,
    parameter logic [31:0] TX_ADDR = 32'h4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             renable,
    input  logic [1:0]       rsize,
    output logic [31:0]      rdata,
    output logic             rdone,
    input  logic             wenable,
    input  logic [1:0]       wsize,
    input  logic [31:0]      wdata,
    output logic             wdone,
    output logic [RX_AW:0]   rx_level,
    output logic [TX_AW:0]   tx_level,
    uart_stream_fifo_if.master uart
);
    localparam int RX_DEPTH = 1 << RX_AW;
    localparam int TX_DEPTH = 1 << TX_AW;
    localparam logic [TX_AW:0] TX_FULL = (TX_AW+1)'(TX_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_RADDR, S_RDATA, S_WADDR, S_WRESP} state_t;

    // Reserved size 10 maps to zero bytes, so it completes at once and
    // moves no data.
    function automatic logic [2:0] size_bytes(input logic [1:0] s);
        case (s)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b11:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;

    logic        rd_pend, wr_pend;
    logic [1:0]  rd_size, wr_size;
    logic [31:0] wr_data;

    logic [2:0]  rd_n, wr_n, rx_pop_n, tx_push_n;
    logic [7:0]  rx_h [4];
    logic [7:0]  wb   [4];
    logic [31:0] rd_word;
    logic [TX_AW:0] tx_free;

    state_t state, state_nx;
    logic   aw_done, w_done, aw_done_nx, w_done_nx;
    logic   rx_push, tx_pop;

    logic unused_bits;
    assign unused_bits = ^{uart.rdata[31:8], uart.rresp[0], uart.bresp[0]};

    // ---------------- core side ----------------
    assign rd_n    = size_bytes(rd_size);
    assign wr_n    = size_bytes(wr_size);
    assign tx_free = TX_FULL - tx_level;

    // Done pulses are gated by rst so a completion that reset is about to
    // discard is never announced.
    assign rdone = rd_pend && (rx_level >= (RX_AW+1)'(rd_n)) && !rst;
    assign wdone = wr_pend && (tx_free  >= (TX_AW+1)'(wr_n)) && !rst;

    assign rx_pop_n  = rdone ? rd_n : 3'd0;
    assign tx_push_n = wdone ? wr_n : 3'd0;

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            rx_h[i] = rx_mem[rx_rd_ptr + RX_AW'(i)];
        end
        case (rd_n)
            3'd1:    rd_word = {24'h0, rx_h[0]};
            3'd2:    rd_word = {16'h0, rx_h[0], rx_h[1]};
            3'd4:    rd_word = {rx_h[0], rx_h[1], rx_h[2], rx_h[3]};
            default: rd_word = '0;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            wb[i] = '0;
        end
        case (wr_n)
            3'd1: wb[0] = wr_data[7:0];
            3'd2: begin
                wb[0] = wr_data[15:8];
                wb[1] = wr_data[7:0];
            end
            3'd4: begin
                wb[0] = wr_data[31:24];
                wb[1] = wr_data[23:16];
                wb[2] = wr_data[15:8];
                wb[3] = wr_data[7:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend <= 1'b0;
            wr_pend <= 1'b0;
            rd_size <= '0;
            wr_size <= '0;
            wr_data <= '0;
            rdata   <= '0;
        end else begin
            if (rd_pend) begin
                if (rdone) begin
                    rd_pend <= 1'b0;
                    rdata   <= rd_word;
                end
            end else if (renable) begin
                rd_pend <= 1'b1;
                rd_size <= rsize;
            end
            if (wr_pend) begin
                if (wdone) wr_pend <= 1'b0;
            end else if (wenable) begin
                wr_pend <= 1'b1;
                wr_size <= wsize;
                wr_data <= wdata;
            end
        end
    end

    // ---------------- FIFO storage and pointers ----------------
    always_ff @(posedge clk) begin
        if (rx_push && !rst) rx_mem[rx_wr_ptr] <= uart.rdata[7:0];
        for (int unsigned i = 0; i < 4; i++) begin
            if (!rst && 3'(i) < tx_push_n) tx_mem[tx_wr_ptr + TX_AW'(i)] <= wb[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            rx_level  <= '0;
            tx_level  <= '0;
        end else begin
            rx_wr_ptr <= rx_wr_ptr + RX_AW'(rx_push);
            rx_rd_ptr <= rx_rd_ptr + RX_AW'(rx_pop_n);
            tx_wr_ptr <= tx_wr_ptr + TX_AW'(tx_push_n);
            tx_rd_ptr <= tx_rd_ptr + TX_AW'(tx_pop);
            rx_level  <= rx_level + (RX_AW+1)'(rx_push) - (RX_AW+1)'(rx_pop_n);
            tx_level  <= tx_level + (TX_AW+1)'(tx_push_n) - (TX_AW+1)'(tx_pop);
        end
    end

    // ---------------- shared AXI engine ----------------
    assign uart.araddr = RX_ADDR;
    assign uart.awaddr = TX_ADDR;
    assign uart.wstrb  = 4'b0001;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_nx;
            aw_done <= aw_done_nx;
            w_done  <= w_done_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        aw_done_nx   = aw_done;
        w_done_nx    = w_done;
        uart.arvalid = 1'b0;
        uart.rready  = 1'b0;
        uart.awvalid = 1'b0;
        uart.wvalid  = 1'b0;
        uart.wdata   = '0;
        uart.bready  = 1'b0;
        rx_push      = 1'b0;
        tx_pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (tx_level != '0) begin
                    state_nx   = S_WADDR;
                    aw_done_nx = 1'b0;
                    w_done_nx  = 1'b0;
                end else if (!rx_level[RX_AW]) begin
                    state_nx = S_RADDR;
                end
            end
            S_RADDR: begin
                uart.arvalid = 1'b1;
                if (uart.arready) state_nx = S_RDATA;
            end
            S_RDATA: begin
                uart.rready = 1'b1;
                if (uart.rvalid) begin
                    rx_push  = !uart.rresp[1];
                    state_nx = S_IDLE;
                end
            end
            S_WADDR: begin
                // Head byte is only peeked here; it leaves the FIFO on OKAY.
                uart.awvalid = !aw_done;
                uart.wvalid  = !w_done;
                uart.wdata   = {24'h0, tx_mem[tx_rd_ptr]};
                aw_done_nx   = aw_done || uart.awready;
                w_done_nx    = w_done  || uart.wready;
                if (aw_done_nx && w_done_nx) state_nx = S_WRESP;
            end
            S_WRESP: begin
                uart.bready = 1'b1;
                if (uart.bvalid) begin
                    if (uart.bresp[1]) begin
                        state_nx   = S_WADDR;
                        aw_done_nx = 1'b0;
                        w_done_nx  = 1'b0;
                    end else begin
                        tx_pop   = 1'b1;
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_stream_fifo.sv
// Directed bench for uart_stream_fifo with a small UART Lite slave model.
// The slave returns bytes from rx_bytes[] while rx_idx < rx_avail (otherwise
// SLVERR = "no data"), records each OKAY-acknowledged TX byte, and answers
// the first err_req write responses with SLVERR.
module tb_uart_stream_fifo;
    logic        clk = 1'b0;
    logic        rst;
    logic        renable, wenable;
    logic [1:0]  rsize, wsize;
    logic [31:0] rdata, wdata;
    logic        rdone, wdone;
    logic [11:0] rx_level;
    logic [9:0]  tx_level;

    uart_stream_fifo_if u ();

    uart_stream_fifo dut (
        .clk(clk), .rst(rst),
        .renable(renable), .rsize(rsize), .rdata(rdata), .rdone(rdone),
        .wenable(wenable), .wsize(wsize), .wdata(wdata), .wdone(wdone),
        .rx_level(rx_level), .tx_level(tx_level), .uart(u)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- slave model ----------------
    logic [7:0]  rx_bytes [8192];
    int          rx_avail = 0;
    int          rx_idx   = 0;
    int          err_req  = 0;
    int          err_used = 0;
    int          ar_count = 0;
    int          aw_count = 0;
    int          berr_count = 0;
    int          tx_cnt   = 0;
    logic [7:0]  tx_seen [256];
    logic [31:0] tx_addr [256];
    logic        aw_got = 1'b0, w_got = 1'b0;
    logic [7:0]  last_wdata = '0;
    logic [31:0] last_awaddr = '0;

    always @(posedge clk) begin
        if (rst) begin
            u.arready <= 1'b0; u.rvalid <= 1'b0; u.rdata <= '0; u.rresp <= '0;
            u.awready <= 1'b0; u.wready <= 1'b0; u.bvalid <= 1'b0; u.bresp <= '0;
            aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            u.arready <= u.arvalid && !u.arready;
            if (u.arvalid && u.arready) begin
                ar_count <= ar_count + 1;
                u.rvalid <= 1'b1;
                if (rx_idx < rx_avail) begin
                    u.rdata <= {24'h0, rx_bytes[rx_idx]};
                    u.rresp <= 2'b00;
                    rx_idx  <= rx_idx + 1;
                end else begin
                    u.rdata <= '0;
                    u.rresp <= 2'b10;
                end
            end else if (u.rvalid && u.rready) begin
                u.rvalid <= 1'b0;
            end

            u.awready <= u.awvalid && !u.awready && !aw_got;
            u.wready  <= u.wvalid && !u.wready && !w_got;
            if (u.awvalid && u.awready) begin
                aw_got      <= 1'b1;
                aw_count    <= aw_count + 1;
                last_awaddr <= u.awaddr;
            end
            if (u.wvalid && u.wready) begin
                w_got      <= 1'b1;
                last_wdata <= u.wdata[7:0];
            end
            if ((aw_got || (u.awvalid && u.awready)) &&
                (w_got || (u.wvalid && u.wready)) && !u.bvalid) begin
                u.bvalid <= 1'b1;
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
                if (err_used < err_req) begin
                    u.bresp  <= 2'b10;
                    err_used <= err_used + 1;
                end else begin
                    u.bresp <= 2'b00;
                end
            end else if (u.bvalid && u.bready) begin
                u.bvalid <= 1'b0;
                if (u.bresp[1]) begin
                    berr_count <= berr_count + 1;
                end else begin
                    tx_seen[tx_cnt[7:0]] <= last_wdata;
                    tx_addr[tx_cnt[7:0]] <= last_awaddr;
                    tx_cnt <= tx_cnt + 1;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic do_read(input logic [1:0] sz, input int budget, output int lat);
        renable = 1'b1; rsize = sz;
        @(negedge clk);
        renable = 1'b0;
        lat = 0;
        while (!rdone && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        check("rd_done", rdone, 1'b1);
        @(negedge clk);
    endtask

    task automatic do_write(input logic [1:0] sz, input logic [31:0] d, input int budget, output int lat);
        wenable = 1'b1; wsize = sz; wdata = d;
        @(negedge clk);
        wenable = 1'b0;
        lat = 0;
        while (!wdone && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        check("wr_done", wdone, 1'b1);
        @(negedge clk);
    endtask

    task automatic wait_rx_level(input int lvl, input int budget, input string tag);
        int k = 0;
        while (int'(rx_level) != lvl && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(rx_level), 32'(lvl));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, k, base, j, a0, tb0, b0, aw0;
        logic seen;
        rst = 1'b1; renable = 1'b0; rsize = '0; wenable = 1'b0; wsize = '0; wdata = '0;
        repeat (3) @(negedge clk);

        check("rst_rdone",   rdone, 1'b0);
        check("rst_wdone",   wdone, 1'b0);
        check("rst_rdata",   rdata, 32'h0);
        check("rst_rxlvl",   32'(rx_level), 32'h0);
        check("rst_txlvl",   32'(tx_level), 32'h0);
        check("rst_arvalid", u.arvalid, 1'b0);
        check("rst_awvalid", u.awvalid, 1'b0);
        check("rst_wvalid",  u.wvalid, 1'b0);
        check("rst_rready",  u.rready, 1'b0);
        check("rst_bready",  u.bready, 1'b0);
        check("rst_awaddr",  u.awaddr, 32'h4);
        check("rst_araddr",  u.araddr, 32'h0);
        check("rst_wstrb",   32'(u.wstrb), 32'h1);
        check("rst_wdata",   u.wdata, 32'h0);
        rst = 1'b0;

        // 1: single byte 'A'
        rx_bytes[0] = 8'h41; rx_avail = 1;
        wait_rx_level(1, 200, "t1_level");
        do_read(2'b00, 20, lat);
        check("t1_lat", 32'(lat), 32'h0);
        check("t1_rdata", rdata, 32'h41);
        check("t1_level_after", 32'(rx_level), 32'h0);

        // 2: word read waits for four bytes; a second pulse is ignored
        renable = 1'b1; rsize = 2'b11;
        @(negedge clk);
        renable = 1'b0;
        check("t2_not_early", rdone, 1'b0);
        renable = 1'b1; rsize = 2'b00;
        @(negedge clk);
        renable = 1'b0;
        repeat (5) @(negedge clk);
        check("t2_still_pend", rdone, 1'b0);
        rx_bytes[1] = 8'h12; rx_bytes[2] = 8'h34; rx_bytes[3] = 8'h56; rx_bytes[4] = 8'h78;
        rx_avail = 5;
        k = 0;
        while (!rdone && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("t2_rdone", rdone, 1'b1);
        check("t2_level_at_done", 32'(rx_level), 32'h4);
        @(negedge clk);
        check("t2_rdata", rdata, 32'h12345678);
        check("t2_level_after", 32'(rx_level), 32'h0);
        check("t2_one_pulse", rdone, 1'b0);

        // 3: word write, MSB byte first on the bus
        tb0 = tx_cnt;
        do_write(2'b11, 32'hDEADBEEF, 20, lat);
        check("t3_lat", 32'(lat), 32'h0);
        check("t3_level", 32'(tx_level), 32'h4);
        k = 0;
        while (tx_cnt < tb0 + 4 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("t3_count", 32'(tx_cnt - tb0), 32'h4);
        check("t3_b0", 32'(tx_seen[tb0]),   32'hDE);
        check("t3_b1", 32'(tx_seen[tb0+1]), 32'hAD);
        check("t3_b2", 32'(tx_seen[tb0+2]), 32'hBE);
        check("t3_b3", 32'(tx_seen[tb0+3]), 32'hEF);
        check("t3_addr0", tx_addr[tb0],   32'h4);
        check("t3_addr3", tx_addr[tb0+3], 32'h4);
        check("t3_level_after", 32'(tx_level), 32'h0);

        // 4: SLVERR on the write response resends the same byte
        tb0 = tx_cnt; b0 = berr_count; aw0 = aw_count;
        err_req = err_req + 1;
        do_write(2'b00, 32'h00000055, 20, lat);
        k = 0;
        while (berr_count == b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t4_berr", 32'(berr_count - b0), 32'h1);
        check("t4_level_hold", 32'(tx_level), 32'h1);
        k = 0;
        while (tx_cnt == tb0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t4_sent", 32'(tx_seen[tb0]), 32'h55);
        check("t4_aw_count", 32'(aw_count - aw0), 32'h2);
        check("t4_level_after", 32'(tx_level), 32'h0);

        // reserved size: immediate completion, no data movement
        tb0 = tx_cnt;
        do_write(2'b10, 32'hFFFFFFFF, 20, lat);
        check("sz10_wlat", 32'(lat), 32'h0);
        check("sz10_txlvl", 32'(tx_level), 32'h0);
        repeat (20) @(negedge clk);
        check("sz10_no_tx", 32'(tx_cnt - tb0), 32'h0);
        do_read(2'b10, 20, lat);
        check("sz10_rlat", 32'(lat), 32'h0);
        check("sz10_rdata", rdata, 32'h0);
        check("sz10_rxlvl", 32'(rx_level), 32'h0);

        // 5: fill RX completely, polling stops, resumes after one pop, wrap
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        base = rx_avail;
        for (int i = 0; i < 7001; i++) rx_bytes[base+i] = 8'(i);
        rx_avail = base + 7001;
        wait_rx_level(2048, 20000, "t5_full");
        a0 = ar_count;
        repeat (30) @(negedge clk);
        check("t5_no_poll", 32'(ar_count - a0), 32'h0);
        check("t5_level_full", 32'(rx_level), 32'd2048);
        do_read(2'b00, 20, lat);
        check("t5_first", rdata, 32'h0);
        a0 = ar_count;
        wait_rx_level(2048, 200, "t5_refill");
        repeat (20) @(negedge clk);
        check("t5_resume", 32'(ar_count - a0), 32'h1);
        j = 1;
        for (int w = 0; w < 512; w++) begin
            do_read(2'b11, 200, lat);
            check("t5_word", rdata, {8'(j), 8'(j+1), 8'(j+2), 8'(j+3)});
            j += 4;
        end

        // 6: reset during RADDR with a write pending
        k = 0;
        while (!(u.arvalid && !u.arready) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t6_in_raddr", u.arvalid, 1'b1);
        wenable = 1'b1; wsize = 2'b11; wdata = 32'hCAFEF00D;
        @(negedge clk);
        wenable = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_raddr_held", u.arvalid, 1'b1);
        check("t6_wdone_in_rst", wdone, 1'b0);
        @(negedge clk);
        check("t6_arvalid", u.arvalid, 1'b0);
        check("t6_txlvl", 32'(tx_level), 32'h0);
        check("t6_rxlvl", 32'(rx_level), 32'h0);
        check("t6_wdone", wdone, 1'b0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (wdone) seen = 1'b1;
        end
        check("t6_wdone_never", seen, 1'b0);
        check("t6_txlvl_after", 32'(tx_level), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
